// File: rtl/cassette_rec.sv
// cassette_rec: records the MC-10 cassette-out FSK stream into the SDRAM tape buffer.
// Full-cycle periods are measured in 1 us ticks, sliced into bits, packed LSB-first
// into bytes and handed to the SDRAM arbiter through a req/ack write port.
module cassette_rec #(
  parameter int unsigned TICK_DIV  = 36,
  parameter int unsigned MIN_US    = 200,
  parameter int unsigned THRESH_US = 625,
  parameter int unsigned MAX_US    = 2000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        cin,
  output logic [24:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic        bit_strobe,
  output logic        bit_val,
  output logic        recording,
  output logic        overflow,
  output logic [24:0] byte_count
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(MAX_US + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state, state_next;
  logic            cin_s1, cin_s2, cin_prev, rise_flag;
  logic            enable_prev;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   period;
  logic [6:0]      shreg;
  logic [2:0]      bit_cnt;

  logic            en_rise_c, tick_c, accept_c, emit_c, bit_c, byte_done_c, ack_c;
  logic [7:0]      new_byte_c;

  assign en_rise_c   = enable & ~enable_prev;
  assign tick_c      = (presc == PW'(TICK_DIV - 1));
  assign ack_c       = wr_req & wr_ack;
  assign byte_done_c = emit_c & (bit_cnt == 3'd7);
  assign new_byte_c  = {bit_c, shreg};

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state and per-edge decode: accept/ignore an edge, emit a bit, time out
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    emit_c     = 1'b0;
    bit_c      = 1'b0;
    if (!enable || en_rise_c) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise_flag) begin
            state_next = S_RUN;
            accept_c   = 1'b1;
          end
        end
        S_RUN: begin
          if (period >= CW'(MAX_US)) begin
            state_next = S_IDLE;
          end else if (rise_flag && (period >= CW'(MIN_US))) begin
            accept_c = 1'b1;
            emit_c   = 1'b1;
            bit_c    = (period < CW'(THRESH_US));
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Input synchroniser, rising-edge flag and enable edge detect
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cin_s1      <= 1'b0;
      cin_s2      <= 1'b0;
      cin_prev    <= 1'b0;
      rise_flag   <= 1'b0;
      enable_prev <= 1'b0;
    end else begin
      cin_s1      <= cin;
      cin_s2      <= cin_s1;
      cin_prev    <= cin_s2;
      rise_flag   <= cin_s2 & ~cin_prev;
      enable_prev <= enable;
    end
  end

  // Microsecond prescaler and saturating period counter, restarted on accepted edges
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc  <= '0;
      period <= '0;
    end else if (accept_c) begin
      presc  <= '0;
      period <= '0;
    end else begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (tick_c && (period != CW'(MAX_US))) period <= period + CW'(1);
    end
  end

  // Bit strobe, bit value and LSB-first byte assembly
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_strobe <= 1'b0;
      bit_val    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      recording  <= 1'b0;
    end else begin
      bit_strobe <= emit_c;
      recording  <= (state_next == S_RUN);
      if (emit_c) begin
        bit_val <= bit_c;
        shreg   <= {bit_c, shreg[6:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // the start edge of a run discards any partial byte
      if (accept_c && (state == S_IDLE)) bit_cnt <= '0;
    end
  end

  // SDRAM write port: byte hand-off, address advance on ack, drop detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_addr    <= '0;
      byte_count <= '0;
      wr_data    <= '0;
      wr_req     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (ack_c) begin
        wr_addr    <= wr_addr + 25'd1;
        byte_count <= byte_count + 25'd1;
      end
      if (byte_done_c && (!wr_req || wr_ack)) begin
        wr_data <= new_byte_c;
        wr_req  <= 1'b1;
      end else if (ack_c) begin
        wr_req <= 1'b0;
      end
      if (byte_done_c && wr_req && !wr_ack) overflow <= 1'b1;
      if (en_rise_c) begin
        wr_addr    <= '0;
        byte_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule
